blck_packer_cntrl: RTL and testbench
====================================

Name: blck_packer_cntrl

Overview:
- Parametrised controller that packs bus words of BUS_SIZE bits into BLCK_SIZE-bit blocks and handles padding at byte granularity.
- Hands each finished block to the permutation core through a valid/ready handshake.
- Supports multi-block messages without re-arming: after a non-last block is consumed, it returns to loading on its own.
- Drives the existing block datapath (shift-in enable, padding enable, per-byte padding-constant mask).

Parameters:
- BUS_SIZE, 32, input bus width in bits; one of 8, 16, 32, 64.
- BLCK_SIZE, 256, block width in bits; a multiple of BUS_SIZE, at least 2*BUS_SIZE.
- PAD_CNST_EN, 1, 1: insert the 0x01 padding constant on partial last blocks; 0: zero-fill only.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  arms the block for a new message; sampled only in IDLE.
- ready  out  1  input word accepted when ready & data_in_valid.
- data_in_valid  in  1  input word valid.
- data_in_nbytes  in  NBW=$clog2(BUS_SIZE/8+1)  count of valid bytes (LSB-first); must equal BUS_SIZE/8 unless data_in_eot.
- data_in_eot  in  1  current word is the last of the message.
- en_update  out  1  datapath shifts one word into the block register.
- en_padding  out  1  datapath shifts in a zero word instead of bus data.
- pad_mask  out  BUS_SIZE/8  one-hot byte lane that receives 0x01 this cycle; all zeros when none.
- blck_out_valid  out  1  block complete and held.
- blck_out_ready  in  1  consumer accepts the block.
- blck_last  out  1  held block is the final block of the message.
- blck_padded  out  1  held block contains padding (constant or zero-fill).

Behaviour:
- Internal constants: W = BLCK_SIZE/BUS_SIZE; word counter width clog2(W)+1.
- Flags: eot_seen, cnst_done, padded.
- States: IDLE, LOAD, PAD, OUT. Every flag and counter is registered.
- Reset: state IDLE, counter 0, all flags 0, all outputs 0. Reset mid-operation aborts the block; no blck_out_valid is produced.
- IDLE:
  - ready = 0.
  - start -> LOAD with counter 0 and all flags cleared.
- LOAD:
  - ready = 1.
  - A handshake (accept) asserts en_update combinationally in the same cycle and increments the counter.
  - Accept with cnt+1 == W: go to OUT. If eot, set eot_seen. If eot with nbytes < BUS_SIZE/8, also apply the partial-word rules below.
  - Accept with eot, 0 < nbytes < BUS_SIZE/8:
    - pad_mask = one-hot(nbytes), only if PAD_CNST_EN.
    - Set cnst_done and padded.
    - Next state PAD, or OUT if the block is now full.
  - Accept with eot, nbytes == BUS_SIZE/8, block not full: set eot_seen; next state PAD with cnst_done = 0.
  - Accept with eot, nbytes == 0 (empty message or empty tail):
    - Behaves as a padding word: en_update = 1, en_padding = 1, pad_mask bit 0 (if PAD_CNST_EN).
    - Set cnst_done and padded; the counter increments.
  - No accept: hold state.
- PAD:
  - ready = 0; en_update = 1 and en_padding = 1 every cycle; padded = 1.
  - First PAD cycle with cnst_done = 0: pad_mask bit 0 (if PAD_CNST_EN), then set cnst_done.
  - Counter increments each cycle; cnt+1 == W -> OUT.
- OUT:
  - blck_out_valid = 1; blck_last = eot_seen; blck_padded = padded. All three hold stable until the handshake.
  - On blck_out_ready:
    - eot_seen -> IDLE.
    - Otherwise -> LOAD with counter 0 and cnst_done/padded cleared. No start is needed.
  - start in OUT is ignored.
- Full-block last word (eot in the word that fills the block): blck_padded = 0, blck_last = 1, no padding cycles.
- Latency:
  - From the accept of the block-filling word to blck_out_valid: 1 cycle.
  - After eot: (W - cnt) PAD cycles, then OUT.
- pad_mask is never asserted without en_update. At most one constant per message.

Test Plan:
- Defaults (32/256, W = 8): start, 8 words, eot on word 8 with nbytes 4 -> 8 en_update pulses; blck_out_valid on the cycle after word 8; blck_last = 1, blck_padded = 0; ready -> IDLE.
- 3 words, eot with nbytes 2 on word 3 -> pad_mask = 4'b0100 on word 3; then 5 PAD cycles with pad_mask 0; OUT with blck_padded = 1, blck_last = 1.
- 2 words, eot with nbytes 4 on word 2 -> 6 PAD cycles; pad_mask = 4'b0001 only on the first; OUT padded.
- Two-block message: 8 words without eot -> OUT with blck_last = 0. Hold blck_out_ready low for 3 cycles: outputs stable, ready = 0. Ready high -> LOAD directly. Second block ends with eot -> blck_last = 1.
- Empty message: start, eot with nbytes 0 -> pad_mask bit 0, then 7 PAD cycles, OUT padded. Repeat with PAD_CNST_EN = 0 -> pad_mask always 0.
- rst asserted in PAD after 2 cycles -> next cycle all outputs 0 and state IDLE. A new start then runs a normal block.

Source files
------------

// File: rtl/blck_packer_cntrl.sv
// Block packer controller: gathers bus words into a block,
// pads partial/last blocks and hands full blocks downstream.
module blck_packer_cntrl #(
  parameter int BUS_SIZE    = 32,
  parameter int BLCK_SIZE   = 256,
  parameter int PAD_CNST_EN = 1,
  localparam int NB  = BUS_SIZE / 8,
  localparam int NBW = $clog2(NB + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           ready,
  input  logic           data_in_valid,
  input  logic [NBW-1:0] data_in_nbytes,
  input  logic           data_in_eot,
  output logic           en_update,
  output logic           en_padding,
  output logic [NB-1:0]  pad_mask,
  output logic           blck_out_valid,
  input  logic           blck_out_ready,
  output logic           blck_last,
  output logic           blck_padded
);

  localparam int W  = BLCK_SIZE / BUS_SIZE;
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0]  WL   = CW'(W);
  localparam logic [NBW-1:0] NBL  = NBW'(NB);
  localparam logic           CNST = (PAD_CNST_EN != 0);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAD,
    OUT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          eot_q, eot_d;
  logic          cnst_q, cnst_d;
  logic          padded_q, padded_d;
  logic          full;

  assign cnt_inc = cnt_q + CW'(1);
  assign full    = (cnt_inc == WL);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    eot_d          = eot_q;
    cnst_d         = cnst_q;
    padded_d       = padded_q;
    ready          = 1'b0;
    en_update      = 1'b0;
    en_padding     = 1'b0;
    pad_mask       = '0;
    blck_out_valid = 1'b0;
    blck_last      = 1'b0;
    blck_padded    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOAD;
          cnt_d    = '0;
          eot_d    = 1'b0;
          cnst_d   = 1'b0;
          padded_d = 1'b0;
        end
      end
      LOAD: begin
        ready = 1'b1;
        if (data_in_valid) begin
          en_update = 1'b1;
          cnt_d     = cnt_inc;
          if (data_in_eot) begin
            eot_d = 1'b1;
            // An empty word (nbytes 0) is a pure padding word
            if (data_in_nbytes < NBL) begin
              cnst_d     = 1'b1;
              padded_d   = 1'b1;
              en_padding = (data_in_nbytes == '0);
              if (CNST) pad_mask = NB'(1) << data_in_nbytes;
            end
          end
          if (full) state_d = OUT;
          else if (data_in_eot) state_d = PAD;
        end
      end
      PAD: begin
        en_update  = 1'b1;
        en_padding = 1'b1;
        padded_d   = 1'b1;
        cnt_d      = cnt_inc;
        if (!cnst_q) begin
          pad_mask[0] = CNST;
          cnst_d      = 1'b1;
        end
        if (full) state_d = OUT;
      end
      OUT: begin
        blck_out_valid = 1'b1;
        blck_last      = eot_q;
        blck_padded    = padded_q;
        if (blck_out_ready) begin
          state_d  = eot_q ? IDLE : LOAD;
          cnt_d    = '0;
          eot_d    = 1'b0;
          cnst_d   = 1'b0;
          padded_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      eot_q    <= 1'b0;
      cnst_q   <= 1'b0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      eot_q    <= eot_d;
      cnst_q   <= cnst_d;
      padded_q <= padded_d;
    end
  end

endmodule

// File: tb/tb_blck_packer_cntrl.sv
// Directed bench for blck_packer_cntrl (32/256, W = 8),
// with a second instance built without the padding constant.
module tb_blck_packer_cntrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       data_in_valid = 1'b0;
  logic [2:0] data_in_nbytes = 3'd0;
  logic       data_in_eot = 1'b0;
  logic       blck_out_ready = 1'b0;

  logic       ready, en_update, en_padding;
  logic [3:0] pad_mask;
  logic       blck_out_valid, blck_last, blck_padded;

  logic       ready1, en_update1, en_padding1;
  logic [3:0] pad_mask1;
  logic       blck_out_valid1, blck_last1, blck_padded1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blck_packer_cntrl #(
    .BUS_SIZE(32), .BLCK_SIZE(256), .PAD_CNST_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .data_in_valid(data_in_valid),
    .data_in_nbytes(data_in_nbytes),
    .data_in_eot(data_in_eot),
    .en_update(en_update), .en_padding(en_padding),
    .pad_mask(pad_mask),
    .blck_out_valid(blck_out_valid),
    .blck_out_ready(blck_out_ready),
    .blck_last(blck_last), .blck_padded(blck_padded)
  );

  blck_packer_cntrl #(
    .BUS_SIZE(32), .BLCK_SIZE(256), .PAD_CNST_EN(0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start), .ready(ready1),
    .data_in_valid(data_in_valid),
    .data_in_nbytes(data_in_nbytes),
    .data_in_eot(data_in_eot),
    .en_update(en_update1), .en_padding(en_padding1),
    .pad_mask(pad_mask1),
    .blck_out_valid(blck_out_valid1),
    .blck_out_ready(blck_out_ready),
    .blck_last(blck_last1), .blck_padded(blck_padded1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_rdy"}, ready, 0);
    chk({tag, "_upd"}, en_update, 0);
    chk({tag, "_pen"}, en_padding, 0);
    chk({tag, "_pm"}, pad_mask, 0);
    chk({tag, "_vld"}, blck_out_valid, 0);
    chk({tag, "_lst"}, blck_last, 0);
    chk({tag, "_pad"}, blck_padded, 0);
  endtask

  task automatic arm;
    start = 1'b1;
    #1;
    chk("idle_rdy", ready, 0);
    tick;
    start = 1'b0;
  endtask

  // n words; the last carries eot/nb and expects mask pm
  task automatic load(input string tag, input int n,
                      input logic eot, input logic [2:0] nb,
                      input logic [3:0] pm);
    for (int i = 0; i < n; i++) begin
      logic lst;
      lst = (i == n - 1);
      data_in_valid  = 1'b1;
      data_in_eot    = lst & eot;
      data_in_nbytes = lst ? nb : 3'd4;
      #1;
      chk({tag, "_rdy"}, ready, 1);
      chk({tag, "_upd"}, en_update, 1);
      chk({tag, "_pen"}, en_padding,
          (lst && eot && nb == 0) ? 1 : 0);
      chk({tag, "_pm"}, pad_mask, (lst && eot) ? pm : 0);
      chk({tag, "_pm1"}, pad_mask1, 0);
      chk({tag, "_vld"}, blck_out_valid, 0);
      tick;
    end
    data_in_valid  = 1'b0;
    data_in_eot    = 1'b0;
    data_in_nbytes = 3'd0;
  endtask

  task automatic pads(input string tag, input int n,
                      input logic [3:0] pm0);
    for (int i = 0; i < n; i++) begin
      #1;
      chk({tag, "_rdy"}, ready, 0);
      chk({tag, "_upd"}, en_update, 1);
      chk({tag, "_pen"}, en_padding, 1);
      chk({tag, "_pm"}, pad_mask, (i == 0) ? pm0 : 0);
      chk({tag, "_pm1"}, pad_mask1, 0);
      chk({tag, "_vld"}, blck_out_valid, 0);
      tick;
    end
  endtask

  task automatic outb(input string tag, input int hold,
                      input logic lst, input logic pd);
    for (int i = 0; i <= hold; i++) begin
      #1;
      chk({tag, "_vld"}, blck_out_valid, 1);
      chk({tag, "_lst"}, blck_last, lst);
      chk({tag, "_pad"}, blck_padded, pd);
      chk({tag, "_rdy"}, ready, 0);
      chk({tag, "_upd"}, en_update, 0);
      if (i < hold) tick;
    end
    blck_out_ready = 1'b1;
    tick;
    blck_out_ready = 1'b0;
  endtask

  initial begin
    tick;
    tick;
    idle_chk("rst");
    rst = 1'b0;
    tick;
    idle_chk("idle");

    // full block, eot on the filling word
    arm;
    load("t1", 8, 1'b1, 3'd4, 4'b0000);
    start = 1'b1;
    outb("t1o", 1, 1'b1, 1'b0);
    start = 1'b0;
    #1;
    idle_chk("t1i");
    tick;

    // 3 words, partial tail of 2 bytes
    arm;
    load("t2", 3, 1'b1, 3'd2, 4'b0100);
    pads("t2p", 5, 4'b0000);
    outb("t2o", 0, 1'b1, 1'b1);
    #1;
    idle_chk("t2i");

    // 2 words, full tail word
    arm;
    load("t3", 2, 1'b1, 3'd4, 4'b0000);
    pads("t3p", 6, 4'b0001);
    outb("t3o", 0, 1'b1, 1'b1);

    // two-block message, back-pressure on the first
    arm;
    load("t4a", 8, 1'b0, 3'd4, 4'b0000);
    outb("t4ao", 3, 1'b0, 1'b0);
    #1;
    chk("t4_reload_rdy", ready, 1);
    load("t4b", 8, 1'b1, 3'd4, 4'b0000);
    outb("t4bo", 0, 1'b1, 1'b0);

    // empty message
    arm;
    load("t5", 1, 1'b1, 3'd0, 4'b0001);
    pads("t5p", 7, 4'b0000);
    outb("t5o", 0, 1'b1, 1'b1);

    // reset in the middle of padding
    arm;
    load("t6", 2, 1'b1, 3'd4, 4'b0000);
    pads("t6p", 2, 4'b0001);
    rst = 1'b1;
    tick;
    idle_chk("t6r");
    rst = 1'b0;
    tick;
    idle_chk("t6i");
    arm;
    load("t7", 8, 1'b1, 3'd4, 4'b0000);
    outb("t7o", 0, 1'b1, 1'b0);
    #1;
    idle_chk("t7i");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
